// File: rtl/usb_rx_ctrl.sv
// ============================================================================
// Module   : usb_rx_ctrl
// Function : USB receive packet controller: SYNC/PID check, payload buffering
//            with CRC-byte holdback, ACK/NAK handshake and error reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_DATA  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       byte_valid,
  input  logic [7:0] rx_byte,
  input  logic       eop,
  input  logic       crc_ok,
  output logic       rx_transfer_active,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       store_data,
  output logic [7:0] rx_data,
  output logic [6:0] rx_data_size
);

  localparam logic [6:0] c_MAX_DATA = 7'(MAX_DATA);
  localparam logic [2:0] c_PKT_DATA = 3'd1;
  localparam logic [2:0] c_PKT_ACK  = 3'd2;
  localparam logic [2:0] c_PKT_NAK  = 3'd3;
  localparam logic [2:0] c_PKT_ERR  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_HS_EOP, S_DONE, S_ERR_WAIT
  } state_t;

  state_t     r_state;
  logic [7:0] r_hold_new;
  logic [7:0] r_hold_old;
  logic [1:0] r_held;
  logic [6:0] r_count;
  logic [2:0] r_result;
  logic       r_active;
  logic [2:0] r_packet;
  logic       r_ready;
  logic       r_store;
  logic [7:0] r_data;
  logic [6:0] r_size;

  logic       w_pid_ok;
  logic       w_full;
  logic       w_store;
  logic       w_ovf;
  logic [1:0] w_held_nxt;
  logic [6:0] w_count_nxt;

  assign w_pid_ok    = (rx_byte[7:4] == ~rx_byte[3:0]);
  assign w_full      = (r_held == 2'd2);
  assign w_store     = (r_state == S_DATA) && byte_valid && w_full && (r_count < c_MAX_DATA);
  assign w_ovf       = (r_state == S_DATA) && byte_valid && w_full && (r_count >= c_MAX_DATA);
  assign w_held_nxt  = (byte_valid && !w_full) ? r_held + 2'd1 : r_held;
  assign w_count_nxt = w_store ? r_count + 7'd1 : r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_hold_new <= 8'h00;
      r_hold_old <= 8'h00;
      r_held     <= 2'd0;
      r_count    <= 7'd0;
      r_result   <= 3'd0;
      r_active   <= 1'b0;
      r_packet   <= 3'd0;
      r_ready    <= 1'b0;
      r_store    <= 1'b0;
      r_data     <= 8'h00;
      r_size     <= 7'd0;
    end else begin
      r_store <= 1'b0;
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (d_edge) begin
            r_state  <= S_SYNC;
            r_active <= 1'b1;
            r_count  <= 7'd0;
            r_held   <= 2'd0;
          end
        end
        S_SYNC: begin
          if (byte_valid) begin
            r_result <= c_PKT_ERR;
            if (rx_byte == SYNC_BYTE && !eop) r_state <= S_PID;
            else if (eop)                     r_state <= S_DONE;
            else                              r_state <= S_ERR_WAIT;
          end else if (eop) begin
            r_result <= c_PKT_ERR;
            r_state  <= S_ERR_WAIT;
          end
        end
        S_PID: begin
          if (byte_valid) begin
            r_result <= c_PKT_ERR;
            if (w_pid_ok && (rx_byte == 8'hC3 || rx_byte == 8'h4B) && !eop) begin
              r_state <= S_DATA;
            end else if (w_pid_ok && (rx_byte == 8'hD2 || rx_byte == 8'h5A)) begin
              r_result <= (rx_byte == 8'hD2) ? c_PKT_ACK : c_PKT_NAK;
              r_state  <= eop ? S_DONE : S_HS_EOP;
            end else begin
              r_state <= eop ? S_DONE : S_ERR_WAIT;
            end
          end else if (eop) begin
            r_result <= c_PKT_ERR;
            r_state  <= S_DONE;
          end
        end
        S_DATA: begin
          if (w_ovf) begin
            r_result <= c_PKT_ERR;
            r_state  <= eop ? S_DONE : S_ERR_WAIT;
          end else begin
            // Two newest bytes are always held back: at eop they are the CRC.
            if (byte_valid) begin
              r_hold_new <= rx_byte;
              r_hold_old <= r_hold_new;
              r_held     <= w_held_nxt;
              r_count    <= w_count_nxt;
              if (w_store) begin
                r_store <= 1'b1;
                r_data  <= r_hold_old;
              end
            end
            if (eop) begin
              r_state  <= S_DONE;
              r_result <= (w_held_nxt == 2'd2 && crc_ok) ? c_PKT_DATA : c_PKT_ERR;
            end
          end
        end
        S_HS_EOP: begin
          if (byte_valid) begin
            r_result <= c_PKT_ERR;
            r_state  <= eop ? S_DONE : S_ERR_WAIT;
          end else if (eop) begin
            r_state <= S_DONE;
          end
        end
        S_ERR_WAIT: begin
          if (eop) begin
            r_result <= c_PKT_ERR;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready  <= 1'b1;
          r_packet <= r_result;
          if (r_result == c_PKT_DATA) r_size <= r_count;
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_transfer_active = r_active;
  assign rx_packet          = r_packet;
  assign rx_data_ready      = r_ready;
  assign store_data         = r_store;
  assign rx_data            = r_data;
  assign rx_data_size       = r_size;

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_ctrl.sv
// ============================================================================
// Module   : tb_usb_rx_ctrl
// Function : Directed self-checking bench for usb_rx_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge, byte_valid, eop, crc_ok;
  logic [7:0] rx_byte;
  logic       rx_transfer_active, rx_data_ready, store_data;
  logic [2:0] rx_packet;
  logic [7:0] rx_data;
  logic [6:0] rx_data_size;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] st_q[$];
  int         ready_cnt = 0;
  int         overlap   = 0;

  usb_rx_ctrl #(.SYNC_BYTE(8'h80), .MAX_DATA(64)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .byte_valid(byte_valid),
    .rx_byte(rx_byte), .eop(eop), .crc_ok(crc_ok),
    .rx_transfer_active(rx_transfer_active), .rx_packet(rx_packet),
    .rx_data_ready(rx_data_ready), .store_data(store_data),
    .rx_data(rx_data), .rx_data_size(rx_data_size)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (n_rst) begin
      if (store_data) st_q.push_back(rx_data);
      if (rx_data_ready) ready_cnt++;
      if (store_data && rx_data_ready) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < st_q.size()) return {24'd0, st_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon;
    st_q.delete();
    ready_cnt = 0;
  endtask

  task automatic start_pkt;
    d_edge = 1'b1;
    tick;
    d_edge = 1'b0;
    tick;
  endtask

  task automatic send(input logic [7:0] b, input logic with_eop, input logic ok);
    byte_valid = 1'b1;
    rx_byte    = b;
    eop        = with_eop;
    crc_ok     = ok;
    tick;
    byte_valid = 1'b0;
    eop        = 1'b0;
    crc_ok     = 1'b0;
    tick;
  endtask

  task automatic end_pkt(input logic ok);
    eop    = 1'b1;
    crc_ok = ok;
    tick;
    eop    = 1'b0;
    crc_ok = 1'b0;
    repeat (4) tick;
  endtask

  task automatic finish_wait;
    repeat (4) tick;
  endtask

  initial begin
    n_rst = 1'b0; d_edge = 1'b0; byte_valid = 1'b0; eop = 1'b0;
    crc_ok = 1'b0; rx_byte = 8'h00;
    tick; tick;
    chk("rst_active", rx_transfer_active, 0);
    chk("rst_packet", rx_packet, 0);
    chk("rst_ready",  rx_data_ready, 0);
    chk("rst_store",  store_data, 0);
    chk("rst_data",   rx_data, 0);
    chk("rst_size",   rx_data_size, 0);
    n_rst = 1'b1;
    tick;

    // ACK handshake
    clr_mon;
    start_pkt;
    chk("ack_active", rx_transfer_active, 1);
    send(8'h80, 1'b0, 1'b0);
    send(8'hD2, 1'b0, 1'b0);
    end_pkt(1'b0);
    chk("ack_packet", rx_packet, 2);
    chk("ack_ready",  ready_cnt, 1);
    chk("ack_stores", st_q.size(), 0);
    chk("ack_idle",   rx_transfer_active, 0);

    // Good DATA0 packet, three payload bytes
    clr_mon;
    start_pkt;
    send(8'h80, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    end_pkt(1'b1);
    chk("d3_nstore", st_q.size(), 3);
    chk("d3_b0", q_at(0), 32'h11);
    chk("d3_b1", q_at(1), 32'h22);
    chk("d3_b2", q_at(2), 32'h33);
    chk("d3_size",   rx_data_size, 3);
    chk("d3_packet", rx_packet, 1);
    chk("d3_ready",  ready_cnt, 1);

    // DATA1 with bad CRC: error result, size unchanged
    clr_mon;
    start_pkt;
    send(8'h80, 1'b0, 1'b0);
    send(8'h4B, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    send(8'h66, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    end_pkt(1'b0);
    chk("crc_packet", rx_packet, 4);
    chk("crc_size",   rx_data_size, 3);
    chk("crc_ready",  ready_cnt, 1);

    // Bad PID check
    clr_mon;
    start_pkt;
    send(8'h80, 1'b0, 1'b0);
    send(8'hC2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b0, 1'b0);
    end_pkt(1'b1);
    chk("pid_stores", st_q.size(), 0);
    chk("pid_packet", rx_packet, 4);
    chk("pid_ready",  ready_cnt, 1);

    // Payload overflow: MAX_DATA+3 bytes
    clr_mon;
    start_pkt;
    send(8'h80, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    for (int i = 1; i <= 67; i++) send(8'(i), 1'b0, 1'b0);
    end_pkt(1'b1);
    chk("ovf_nstore", st_q.size(), 64);
    chk("ovf_first",  q_at(0), 32'h01);
    chk("ovf_last",   q_at(63), 32'h40);
    chk("ovf_packet", rx_packet, 4);
    chk("ovf_size",   rx_data_size, 3);

    // Last CRC byte coincides with eop
    clr_mon;
    start_pkt;
    send(8'h80, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    send(8'h99, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b1, 1'b1);
    finish_wait;
    chk("se_nstore", st_q.size(), 1);
    chk("se_b0",     q_at(0), 32'h99);
    chk("se_size",   rx_data_size, 1);
    chk("se_packet", rx_packet, 1);

    // NAK PID arriving together with eop
    clr_mon;
    start_pkt;
    send(8'h80, 1'b0, 1'b0);
    send(8'h5A, 1'b1, 1'b0);
    finish_wait;
    chk("nak_packet", rx_packet, 3);
    chk("nak_ready",  ready_cnt, 1);

    // Reset mid-packet
    clr_mon;
    start_pkt;
    send(8'h80, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    n_rst = 1'b0;
    #2;
    chk("mr_active", rx_transfer_active, 0);
    chk("mr_packet", rx_packet, 0);
    chk("mr_size",   rx_data_size, 0);
    chk("mr_data",   rx_data, 0);
    tick;
    n_rst = 1'b1;
    repeat (3) tick;
    chk("mr_ready", ready_cnt, 0);
    chk("mr_inactive", rx_transfer_active, 0);
    start_pkt;
    send(8'h80, 1'b0, 1'b0);
    send(8'hD2, 1'b0, 1'b0);
    end_pkt(1'b0);
    chk("mr_ack_packet", rx_packet, 2);
    chk("mr_ack_ready",  ready_cnt, 1);
    chk("mr_ack_stores", st_q.size(), 0);

    chk("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_rx_ctrl.md
USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, 8'h80, byte value the decoder delivers for a valid SYNC field.
REQ-002 Parameter MAX_DATA, 64, maximum payload bytes per DATA packet (CRC excluded).
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 n_rst  in  1  reset, asynchronous, active-low.
REQ-005 d_edge  in  1  one-cycle pulse, first bus transition detected while the bus is idle.
REQ-006 byte_valid  in  1  one-cycle pulse, rx_byte holds a complete decoded byte.
REQ-007 rx_byte  in  8  decoded byte, valid only with byte_valid.
REQ-008 eop  in  1  one-cycle pulse, end-of-packet (SE0 then J) detected.
REQ-009 crc_ok  in  1  external CRC16 residue check result, sampled on the eop cycle.
REQ-010 rx_transfer_active  out  1  high from packet start until the packet is resolved.
REQ-011 rx_packet  out  3  result: 0 none, 1 DATA, 2 ACK, 3 NAK, 4 error.
REQ-012 rx_data_ready  out  1  one-cycle pulse, rx_packet holds a new result.
REQ-013 store_data  out  1  one-cycle pulse, write rx_data to the data buffer.
REQ-014 rx_data  out  8  payload byte, valid with store_data.
REQ-015 rx_data_size  out  7  payload byte count of the last DATA packet.

Function
REQ-016 States: IDLE, SYNC, PID, DATA, HS_EOP, DONE, ERR_WAIT; all outputs registered.
REQ-017 IDLE: on d_edge -> SYNC, rx_transfer_active=1 the next cycle, payload counter cleared.
REQ-018 SYNC: on byte_valid, rx_byte==SYNC_BYTE -> PID; any other byte -> ERR_WAIT; eop -> ERR_WAIT.
REQ-019 PID: rx_byte[7:4] SHALL equal ~rx_byte[3:0], otherwise ERR_WAIT. 8'hC3 (DATA0) or 8'h4B (DATA1) -> DATA. 8'hD2 -> HS_EOP, type ACK. 8'h5A -> HS_EOP, type NAK. Other valid PIDs -> ERR_WAIT.
REQ-020 DATA: two-deep byte holding pipeline. On each byte_valid the oldest held byte goes to rx_data with store_data=1, but only when both stages are already full. The counter increments on each such store.
REQ-021 Bytes 1 and 2 of DATA produce no store. The final two held bytes at eop are the CRC and are never stored.
REQ-022 DATA on eop: with at least 2 bytes held and crc_ok=1 -> DONE, rx_packet=1, rx_data_size=count. Otherwise rx_packet=4.
REQ-023 DATA: a byte_valid that would make count exceed MAX_DATA+2 total bytes -> ERR_WAIT; that byte is not stored.
REQ-024 HS_EOP: eop -> DONE with the latched type. A byte_valid before eop -> ERR_WAIT.
REQ-025 ERR_WAIT: ignore all bytes; on eop -> DONE with rx_packet=4.
REQ-026 DONE: assert rx_data_ready for exactly one cycle, clear rx_transfer_active, return to IDLE the next cycle.
REQ-027 rx_packet holds its value until the next rx_data_ready. rx_data_size holds until the next DATA result.
REQ-028 byte_valid and eop in the same cycle: process the byte first, then the eop, both in that cycle's transition.
REQ-029 d_edge is ignored outside IDLE.
REQ-030 store_data and rx_data_ready are never high in the same cycle.

Reset
REQ-031 n_rst low forces IDLE and clears the holding pipeline and counter. All outputs go to 0: rx_transfer_active, rx_packet, rx_data_ready, store_data, rx_data, rx_data_size.
REQ-032 Reset asserted mid-packet abandons the packet with no rx_data_ready pulse. After release, the block waits for the next d_edge.

Verification
REQ-033 d_edge, 80, D2, eop -> rx_packet=2, one rx_data_ready pulse, no store_data.
REQ-034 d_edge, 80, C3, 11, 22, 33, CRC bytes AA BB, eop with crc_ok=1 -> stores 11, 22, 33 in order; rx_data_size=3; rx_packet=1.
REQ-035 Same as REQ-034 with crc_ok=0 -> rx_packet=4; rx_data_size keeps its previous value.
REQ-036 d_edge, 80, C2 (bad PID check), 5 more bytes, eop -> no store_data, rx_packet=4 after eop.
REQ-037 d_edge, 80, C3, then MAX_DATA+3 bytes -> ERR_WAIT after byte MAX_DATA+3; stores stop at MAX_DATA; rx_packet=4 on eop.
REQ-038 n_rst pulsed after 2 payload bytes -> all outputs 0, no rx_data_ready. A following ACK packet is received correctly.
